// File: rtl/booth_mul_seq_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// booth_mul_seq_if : start/operand/result bundle of the sequential multiplier
// Revision: 1.0
// ----------------------------------------------------------------------------
interface booth_mul_seq_if;
  logic        start;
  logic [31:0] RM;
  logic [31:0] RQ;
  logic        busy;
  logic        done;
  logic [31:0] Zhi;
  logic [31:0] Zlo;

  modport master (output start, RM, RQ, input busy, done, Zhi, Zlo);
  modport slave  (input start, RM, RQ, output busy, done, Zhi, Zlo);
endinterface
`default_nettype wire

// File: rtl/booth_mul_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// booth_mul_seq : radix-4 Booth multiplier, 32x32 signed -> 64, 16 CALC cycles
// Revision: 1.0
// ----------------------------------------------------------------------------
module booth_mul_seq (
  input  logic             clk,
  input  logic             clr_n,
  booth_mul_seq_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] mq_q, mq_d;
  logic [31:0] mm_q, mm_d;
  logic [63:0] acc_q, acc_d;
  logic [3:0]  step_q, step_d;
  logic [31:0] zhi_q, zhi_d;
  logic [31:0] zlo_q, zlo_d;

  logic [32:0] mq_ext;
  logic [2:0]  trip;
  logic [63:0] mm_ext;
  logic [63:0] pp;
  logic [63:0] sum;

  // Datapath: recode one multiplier triplet and add its shifted partial product.
  always_comb begin
    mq_ext = {mq_q, 1'b0};
    trip   = mq_ext[{step_q, 1'b0} +: 3];
    mm_ext = {{32{mm_q[31]}}, mm_q};
    pp     = 64'd0;
    case (trip)
      3'b001, 3'b010: pp = mm_ext;
      3'b011:         pp = mm_ext << 1;
      3'b100:         pp = -(mm_ext << 1);
      3'b101, 3'b110: pp = -mm_ext;
      default:        pp = 64'd0;
    endcase
    sum = acc_q + (pp << {step_q, 1'b0});
  end

  always_comb begin
    state_d = state_q;
    mq_d    = mq_q;
    mm_d    = mm_q;
    acc_d   = acc_q;
    step_d  = step_q;
    zhi_d   = zhi_q;
    zlo_d   = zlo_q;
    case (state_q)
      CALC: begin
        acc_d  = sum;
        step_d = step_q + 4'd1;
        if (step_q == 4'd15) begin
          {zhi_d, zlo_d} = sum;
          state_d        = DONE;
        end
      end
      IDLE, DONE: begin
        if (bus.start) begin
          mq_d    = bus.RQ;
          mm_d    = bus.RM;
          acc_d   = 64'd0;
          step_d  = 4'd0;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      mq_q    <= 32'd0;
      mm_q    <= 32'd0;
      acc_q   <= 64'd0;
      step_q  <= 4'd0;
      zhi_q   <= 32'd0;
      zlo_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      mq_q    <= mq_d;
      mm_q    <= mm_d;
      acc_q   <= acc_d;
      step_q  <= step_d;
      zhi_q   <= zhi_d;
      zlo_q   <= zlo_d;
    end
  end

  assign bus.busy = (state_q == CALC);
  assign bus.done = (state_q == DONE);
  assign bus.Zhi  = zhi_q;
  assign bus.Zlo  = zlo_q;

endmodule
`default_nettype wire

// File: tb/tb_booth_mul_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_booth_mul_seq : random + directed bench against a cycle-count product model
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_booth_mul_seq;

  logic clk;
  logic clr_n;
  int   n_checks;
  int   n_fail;

  booth_mul_seq_if bus ();

  booth_mul_seq dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: accept start when not calculating, then the product appears 16 edges later.
  int          m_phase;
  int          m_left;
  logic [63:0] m_pend;
  logic [63:0] m_z;

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      m_phase <= 0;
      m_left  <= 0;
      m_pend  <= 64'd0;
      m_z     <= 64'd0;
    end else if (m_phase == 1) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_z     <= m_pend;
        m_phase <= 2;
      end
    end else if (bus.start) begin
      m_pend  <= 64'(longint'($signed(bus.RM)) * longint'($signed(bus.RQ)));
      m_left  <= 16;
      m_phase <= 1;
    end else begin
      m_phase <= 0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (clr_n) begin
      chk("busy", {63'd0, bus.busy}, {63'd0, m_phase == 1});
      chk("done", {63'd0, bus.done}, {63'd0, m_phase == 2});
      chk("result", {bus.Zhi, bus.Zlo}, m_z);
    end
  end

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input string name,
                        output int busy_cnt);
    bit found;
    found = 1'b0;
    @(negedge clk);
    bus.RM    = a;
    bus.RQ    = b;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.RM    = $urandom;
    bus.RQ    = $urandom;
    busy_cnt  = bus.busy ? 1 : 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (bus.done) found = 1'b1;
      else if (bus.busy) busy_cnt++;
    end
    chk({name, "_done_seen"}, {63'd0, found}, 64'd1);
    chk(name, {bus.Zhi, bus.Zlo}, exp);
    chk({name, "_model"}, m_z, exp);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 9))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      4: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          bc;
    int          dcnt;
    int          first, second;
    logic [63:0] z1, z2, zpre, zdone;
    logic [31:0] a, b;
    logic [63:0] e;

    n_checks  = 0;
    n_fail    = 0;
    clr_n     = 1'b0;
    bus.start = 1'b0;
    bus.RM    = 32'd0;
    bus.RQ    = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_done", {63'd0, bus.done}, 64'd0);
    chk("rst_result", {bus.Zhi, bus.Zlo}, 64'd0);
    clr_n = 1'b1;

    // Directed vectors with hand-computed products.
    run_op(32'd3, 32'd5, 64'h0000_0000_0000_000F, "basic_3x5", bc);
    chk("basic_busy_cycles", 64'(bc), 64'd16);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, "neg1xneg1", bc);
    run_op(32'hFFFF_FFFE, 32'd7, 64'hFFFF_FFFF_FFFF_FFF2, "neg2x7", bc);
    run_op(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "min_x_min", bc);
    run_op(32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000, "min_x_max", bc);

    // start and new operands mid-CALC are ignored.
    @(negedge clk);
    bus.RM = 32'd3; bus.RQ = 32'd5; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    bus.RM = 32'd9; bus.RQ = 32'd9; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    dcnt  = 0;
    zdone = 64'd0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) begin
        dcnt++;
        zdone = {bus.Zhi, bus.Zlo};
      end
    end
    chk("midcalc_done_count", 64'(dcnt), 64'd1);
    chk("midcalc_result", zdone, 64'd15);

    // start held through DONE: second acceptance one edge after done rises.
    @(negedge clk);
    bus.RM = 32'd3; bus.RQ = 32'd5; bus.start = 1'b1;
    first = 0; second = 0; z1 = 64'd0; z2 = 64'd0; zpre = 64'd0;
    for (int i = 1; i <= 60 && second == 0; i++) begin
      @(negedge clk);
      if (bus.done) begin
        if (first == 0) begin
          first  = i;
          z1     = {bus.Zhi, bus.Zlo};
          bus.RM = 32'd7;
          bus.RQ = 32'd11;
        end else begin
          second    = i;
          z2        = {bus.Zhi, bus.Zlo};
          bus.start = 1'b0;
        end
      end else if (first != 0) begin
        zpre = {bus.Zhi, bus.Zlo};
      end
    end
    bus.start = 1'b0;
    chk("b2b_first_done", 64'(first), 64'd17);
    chk("b2b_spacing", 64'(second - first), 64'd17);
    chk("b2b_first_result", z1, 64'd15);
    chk("b2b_held_result", zpre, 64'd15);
    chk("b2b_second_result", z2, 64'd77);
    repeat (2) @(negedge clk);

    // Asynchronous reset at CALC step 7, between edges.
    bus.RM = 32'd3; bus.RQ = 32'd5; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    #2 clr_n = 1'b0;
    #1;
    chk("arst_busy", {63'd0, bus.busy}, 64'd0);
    chk("arst_done", {63'd0, bus.done}, 64'd0);
    chk("arst_result", {bus.Zhi, bus.Zlo}, 64'd0);
    @(negedge clk);
    clr_n = 1'b1;
    dcnt  = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.done) dcnt++;
    end
    chk("arst_no_done", 64'(dcnt), 64'd0);
    run_op(32'd3, 32'd5, 64'd15, "after_rst_3x5", bc);

    // Random operands, corner values mixed in.
    for (int n = 0; n < 2000; n++) begin
      a = pick();
      b = pick();
      e = 64'(longint'($signed(a)) * longint'($signed(b)));
      run_op(a, b, e, "rand", bc);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
